// File: rtl/nes_poll_scheduler.sv
// rtl/nes_poll_scheduler.sv - NES controller poll sequencer with auto/requested polling
//
// Purpose: drives the controller latch and shift clock, samples the serial
// data line and publishes a registered 8-button word to game logic.
// Polls every PERIOD_CYC cycles (0 disables) and on poll_req.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-low reset
//   poll_req     in   single-cycle request for an immediate poll
//   data         in   serial button data from the controller
//   latch        out  controller latch strobe (registered)
//   nes_clk      out  controller shift clock (registered)
//   buttons      out  [0]=A [1]=B [2]=Select [3]=Start [4]=Up [5]=Down [6]=Left [7]=Right, 1=pressed
//   valid        out  one-cycle pulse when buttons updates
//   pressed_edge out  newly pressed buttons, coincident with valid
//   busy         out  high while a poll sequence is in progress
//
// Optional feature macro: NES_DEBOUNCE_EN - a sampled word is committed only
// when it matches the word from the previous completed poll.

module nes_poll_scheduler #(
    parameter int LATCH_CYC        = 600,
    parameter int HALF_CYC         = 300,
    parameter int PERIOD_CYC       = 833333,
    parameter int DATA_ACTIVE_HIGH = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       poll_req,
    input  logic       data,
    output logic       latch,
    output logic       nes_clk,
    output logic [7:0] buttons,
    output logic       valid,
    output logic [7:0] pressed_edge,
    output logic       busy
);

    localparam int MAX_A = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
    localparam int MAX_P = (MAX_A > PERIOD_CYC) ? MAX_A : PERIOD_CYC;
    localparam int CW    = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] LATCH_LAST  = CW'(LATCH_CYC - 1);
    localparam logic [CW-1:0] HALF_LAST   = CW'(HALF_CYC - 1);
    localparam logic [CW-1:0] PERIOD_LAST = (PERIOD_CYC > 0) ? CW'(PERIOD_CYC - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_LOW   = 3'd2,
        S_HIGH  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] phase_q, phase_d;
    logic [CW-1:0] period_q, period_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    buttons_q, buttons_d;
    logic [7:0]    pressed_q, pressed_d;
    logic          pending_q, pending_d;
    logic          valid_q, valid_d;
    logic          latch_q, latch_d;
    logic          nes_clk_q, nes_clk_d;
`ifdef NES_DEBOUNCE_EN
    logic [7:0]    cand_q, cand_d;
`endif

    logic auto_trig;
    logic trigger;
    logic sample;

    assign auto_trig = (PERIOD_CYC != 0) && (period_q == PERIOD_LAST);
    assign trigger   = poll_req | auto_trig;
    assign sample    = (DATA_ACTIVE_HIGH != 0) ? data : ~data;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q + CW'(1);
        bit_d     = bit_q;
        shift_d   = shift_q;
        buttons_d = buttons_q;
        pressed_d = '0;
        valid_d   = 1'b0;
        pending_d = pending_q;
`ifdef NES_DEBOUNCE_EN
        cand_d    = cand_q;
`endif

        // Free-running period counter, independent of the poll FSM
        if (PERIOD_CYC == 0 || period_q == PERIOD_LAST) begin
            period_d = '0;
        end else begin
            period_d = period_q + CW'(1);
        end

        // A trigger arriving mid-poll is remembered once; extras are dropped
        if (state_q != S_IDLE && trigger) begin
            pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                phase_d = '0;
                bit_d   = '0;
                if (trigger || pending_q) begin
                    pending_d = 1'b0;
                    state_d   = S_LATCH;
                end
            end
            S_LATCH: begin
                if (phase_q == LATCH_LAST) begin
                    phase_d = '0;
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                // Sample at the end of the low half, just before the next rising nes_clk
                if (phase_q == HALF_LAST) begin
                    phase_d        = '0;
                    shift_d[bit_q] = sample;
                    bit_d          = bit_q + 3'd1;
                    state_d        = (bit_q == 3'd7) ? S_DONE : S_HIGH;
                end
            end
            S_HIGH: begin
                if (phase_q == HALF_LAST) begin
                    phase_d = '0;
                    state_d = S_LOW;
                end
            end
            S_DONE: begin
                phase_d = '0;
                state_d = S_IDLE;
`ifdef NES_DEBOUNCE_EN
                cand_d = shift_q;
                if (shift_q == cand_q) begin
                    buttons_d = shift_q;
                    pressed_d = shift_q & ~buttons_q;
                    valid_d   = 1'b1;
                end
`else
                buttons_d = shift_q;
                pressed_d = shift_q & ~buttons_q;
                valid_d   = 1'b1;
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Pin outputs follow the next state so they are registered and mutually exclusive
        latch_d   = (state_d == S_LATCH);
        nes_clk_d = (state_d == S_HIGH);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            period_q  <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            buttons_q <= '0;
            pressed_q <= '0;
            pending_q <= 1'b0;
            valid_q   <= 1'b0;
            latch_q   <= 1'b0;
            nes_clk_q <= 1'b0;
`ifdef NES_DEBOUNCE_EN
            cand_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            period_q  <= period_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            buttons_q <= buttons_d;
            pressed_q <= pressed_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            latch_q   <= latch_d;
            nes_clk_q <= nes_clk_d;
`ifdef NES_DEBOUNCE_EN
            cand_q    <= cand_d;
`endif
        end
    end

    assign latch        = latch_q;
    assign nes_clk      = nes_clk_q;
    assign buttons      = buttons_q;
    assign valid        = valid_q;
    assign pressed_edge = pressed_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_nes_poll_scheduler.sv
// tb/tb_nes_poll_scheduler.sv - directed scoreboard bench for nes_poll_scheduler

module tb_nes_poll_scheduler;

    logic       clk = 1'b0;
    logic       resetn0 = 1'b0;
    logic       resetn1 = 1'b0;
    logic       poll_req = 1'b0;
    logic       data0 = 1'b0;
    logic       data1 = 1'b0;
    logic       latch0, nes0, valid0, busy0;
    logic [7:0] buttons0, pe0;
    logic       latch1, nes1, valid1, busy1;
    logic [7:0] buttons1, pe1;

    always #10 clk = ~clk;

    nes_poll_scheduler #(
        .LATCH_CYC(600), .HALF_CYC(300), .PERIOD_CYC(0), .DATA_ACTIVE_HIGH(1)
    ) dut0 (
        .clk(clk), .reset(resetn0), .poll_req(poll_req), .data(data0),
        .latch(latch0), .nes_clk(nes0), .buttons(buttons0), .valid(valid0),
        .pressed_edge(pe0), .busy(busy0)
    );

    nes_poll_scheduler #(
        .LATCH_CYC(600), .HALF_CYC(300), .PERIOD_CYC(10000), .DATA_ACTIVE_HIGH(0)
    ) dut1 (
        .clk(clk), .reset(resetn1), .poll_req(1'b0), .data(data1),
        .latch(latch1), .nes_clk(nes1), .buttons(buttons1), .valid(valid1),
        .pressed_edge(pe1), .busy(busy1)
    );

    typedef struct {
        logic [7:0] b;
        logic [7:0] pe;
        int         t;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   vcount = 0;
    int   llen = 0;
    int   nrise = 0;
    int   idx = 0;
    logic lprev = 1'b0, nprev = 1'b0, l1prev = 1'b0;
    logic overlap = 1'b0;
    logic [7:0] word0 = 8'h00;
    int   rises1[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Controller model: latch reloads bit 0, each nes_clk rise shifts to the next bit
    always @(negedge clk) begin
        if (latch0) idx = 0;
        else if (nes0 && !nprev && idx < 7) idx = idx + 1;
        data0 = word0[idx[2:0]];
    end

    // Scoreboard monitor for dut0 plus waveform shape tracking
    always @(negedge clk) begin
        exp_t e;
        if (latch0 && !lprev) begin
            llen  = 0;
            nrise = 0;
        end
        if (latch0) llen++;
        if (nes0 && !nprev) nrise++;
        if ((latch0 && nes0) || (latch1 && nes1)) overlap = 1'b1;
        if (latch1 && !l1prev) rises1.push_back(cyc);
        lprev  = latch0;
        nprev  = nes0;
        l1prev = latch1;
        if (valid0) begin
            vcount++;
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'(valid0), 32'd0);
            end else begin
                e = sb.pop_front();
                check("buttons", 32'(buttons0), 32'(e.b));
                check("pressed_edge", 32'(pe0), 32'(e.pe));
                if (e.t >= 0) check("valid_time", 32'(cyc), 32'(e.t));
                check("nes_clk_rises", 32'(nrise), 32'd7);
                check("latch_len", 32'(llen), 32'd600);
            end
        end
    end

    task automatic pulse_req(output int rc);
        @(negedge clk);
        poll_req = 1'b1;
        rc = cyc;
        @(negedge clk);
        poll_req = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (sb.size() != 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int rc;
        int v0;
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_latch", 32'(latch0), 32'd0);
        check("rst_nes_clk", 32'(nes0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_buttons", 32'(buttons0), 32'd0);
        check("rst_valid", 32'(valid0), 32'd0);
        check("rst_pe", 32'(pe0), 32'd0);
        repeat (2) @(negedge clk);
        resetn0 = 1'b1;
        resetn1 = 1'b1;

        // Reset mid-LATCH aborts the poll with no valid
        word0 = 8'hA5;
        pulse_req(rc);
        repeat (99) @(negedge clk);
        check("midlatch_latch", 32'(latch0), 32'd1);
        check("midlatch_busy", 32'(busy0), 32'd1);
        resetn0 = 1'b0;
        @(negedge clk);
        check("abort_latch", 32'(latch0), 32'd0);
        check("abort_nes_clk", 32'(nes0), 32'd0);
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_buttons", 32'(buttons0), 32'd0);
        repeat (4) @(negedge clk);
        resetn0 = 1'b1;
        repeat (10000) @(negedge clk);
        check("abort_no_valid", 32'(vcount), 32'd0);

`ifdef NES_DEBOUNCE_EN
        word0 = 8'h01;
        pulse_req(rc);
        repeat (5200) @(negedge clk);
        check("db_first_hold", 32'(buttons0), 32'd0);
        sb.push_back('{8'h01, 8'h01, -1});
        pulse_req(rc);
        drain(6000);
        word0 = 8'h02;
        v0 = vcount;
        pulse_req(rc);
        repeat (5200) @(negedge clk);
        check("db_change_hold", 32'(buttons0), 32'h01);
        check("db_change_novalid", 32'(vcount), 32'(v0));
`else
        // First poll: latency, waveform shape, word F7
        word0 = 8'hF7;
        pulse_req(rc);
        sb.push_back('{8'hF7, 8'hF7, rc + 5102});
        drain(6000);

        // Second poll: Start pressed, Up released
        word0 = 8'hEF;
        pulse_req(rc);
        sb.push_back('{8'hEF, 8'h08, rc + 5102});
        drain(6000);

        // Requests during a running poll collapse into one pending poll
        pulse_req(rc);
        sb.push_back('{8'hEF, 8'h00, rc + 5102});
        sb.push_back('{8'hEF, 8'h00, rc + 10204});
        v0 = vcount;
        repeat (97) @(negedge clk);
        pulse_req(n);
        repeat (100) @(negedge clk);
        pulse_req(n);
        repeat (100) @(negedge clk);
        pulse_req(n);
        n = 0;
        while (!valid0 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("pend_gap_busy", 32'(busy0), 32'd0);
        check("pend_gap_latch", 32'(latch0), 32'd0);
        @(negedge clk);
        check("pend_restart_latch", 32'(latch0), 32'd1);
        check("pend_restart_busy", 32'(busy0), 32'd1);
        drain(6000);
        repeat (6000) @(negedge clk);
        check("pend_poll_count", 32'(vcount - v0), 32'd2);
`endif

        // Auto-poll dut: spacing and inverted data
        check("auto_rises_ge3", 32'(rises1.size() >= 3), 32'd1);
        for (int i = 1; i < rises1.size(); i++) begin
            check("auto_spacing", 32'(rises1[i] - rises1[i-1]), 32'd10000);
        end
        check("auto_inverted_buttons", 32'(buttons1), 32'hFF);
        check("latch_nes_overlap", 32'(overlap), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
